tr_defuzzy_seq: RTL and testbench



---
 rtl/tr_defuzzy_seq_pkg.sv | 47 ++++
 rtl/tr_defuzzy_seq_if.sv | 32 +++
 rtl/tr_defuzzy_seq_divider.sv | 69 ++++++
 rtl/tr_defuzzy_seq.sv | 165 ++++++++++++++++
 tb/tb_tr_defuzzy_seq.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/tr_defuzzy_seq_pkg.sv
// Shared definitions for the sequenced type-reduction / defuzzification block.
// Holds the FSM state encoding, the datapath width constants, the divider
// iteration count and the final quotient-to-output conversion, which also
// handles optional round-to-nearest.
package tr_defuzzy_seq_pkg;

    localparam int MF_W     = 8;   // membership / firing strength width
    localparam int FOU_W    = 9;   // UP + LOW, max 510
    localparam int NUM_W    = 19;  // weighted position sum
    localparam int DEN_W    = 11;  // total weight, max 1530
    localparam int OUT_W    = 8;   // crisp output
    localparam int DIV_ITER = 19;  // one restoring step per numerator bit
    localparam int CNT_W    = 5;   // iteration counter width

    typedef enum logic [1:0] {
        STATE_IDLE = 2'd0,
        STATE_SUM  = 2'd1,
        STATE_DIV  = 2'd2,
        STATE_DONE = 2'd3
    } state_e;

    // Convert the divider result into the 8-bit crisp value. With round_en
    // set, the quotient is bumped when the remainder is at least half the
    // divisor. The result saturates at 255 in both modes; a weighted mean
    // of 8-bit positions never exceeds 255, so truncation stays bit-exact
    // with the old combinational divider.
    function automatic logic [OUT_W-1:0] round_quot(
        input logic [NUM_W-1:0] quot,
        input logic [DEN_W-1:0] rem,
        input logic [DEN_W-1:0] den,
        input logic             round_en
    );
        logic [DEN_W:0]     rem2;
        logic [OUT_W-1:0]   res;
        rem2 = {rem, 1'b0};
        if (|quot[NUM_W-1:OUT_W]) begin
            res = {OUT_W{1'b1}};
        end else if (round_en && (rem2 >= {1'b0, den}) &&
                     (quot[OUT_W-1:0] != {OUT_W{1'b1}})) begin
            res = quot[OUT_W-1:0] + {{(OUT_W-1){1'b0}}, 1'b1};
        end else begin
            res = quot[OUT_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/tr_defuzzy_seq_if.sv
// Bus bundle between the inference stage / actuator side and tr_defuzzy_seq.
//   master : drives EN_SCLK and the six firing strengths, observes results
//   slave  : the defuzzifier; drives saida, valid, busy, div_zero, overrun
interface tr_defuzzy_seq_if;
    import tr_defuzzy_seq_pkg::*;

    logic              EN_SCLK;
    logic [MF_W-1:0]   FOU_1_UP;
    logic [MF_W-1:0]   FOU_2_UP;
    logic [MF_W-1:0]   FOU_3_UP;
    logic [MF_W-1:0]   FOU_1_LOW;
    logic [MF_W-1:0]   FOU_2_LOW;
    logic [MF_W-1:0]   FOU_3_LOW;
    logic [OUT_W-1:0]  saida;
    logic              valid;
    logic              busy;
    logic              div_zero;
    logic              overrun;

    modport master (
        output EN_SCLK, FOU_1_UP, FOU_2_UP, FOU_3_UP,
               FOU_1_LOW, FOU_2_LOW, FOU_3_LOW,
        input  saida, valid, busy, div_zero, overrun
    );

    modport slave (
        input  EN_SCLK, FOU_1_UP, FOU_2_UP, FOU_3_UP,
               FOU_1_LOW, FOU_2_LOW, FOU_3_LOW,
        output saida, valid, busy, div_zero, overrun
    );

endinterface

// File: rtl/tr_defuzzy_seq_divider.sv
// seq_divider: radix-2 restoring divider, one quotient bit per step.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : latch num/den, clear remainder and iteration counter
//   step       : perform one shift/subtract iteration (MSB of num first)
//   num, den   : dividend (19 bit) and divisor (11 bit, nonzero when loaded)
//   quotient   : quotient, valid after DIV_ITER steps
//   remainder  : remainder, valid after DIV_ITER steps
//   last       : the step performed this cycle is the final one
module seq_divider
    import tr_defuzzy_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic [NUM_W-1:0] quotient,
    output logic [DEN_W-1:0] remainder,
    output logic             last
);

    // The dividend shifts out of the top of quot_r while quotient bits
    // shift in at the bottom, so one register serves both roles.
    logic [NUM_W-1:0] quot_r;
    logic [DEN_W-1:0] rem_r;
    logic [DEN_W-1:0] den_r;
    logic [CNT_W-1:0] cnt_r;
    logic [DEN_W:0]   rem_shift_s;
    logic [DEN_W:0]   rem_diff_s;
    logic             fits_s;

    // Trial subtraction for the current step
    always_comb begin
        rem_shift_s = {rem_r, quot_r[NUM_W-1]};
        fits_s      = (rem_shift_s >= {1'b0, den_r});
        rem_diff_s  = rem_shift_s - {1'b0, den_r};
    end

    // Shift/subtract registers and iteration counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quot_r <= {NUM_W{1'b0}};
            rem_r  <= {DEN_W{1'b0}};
            den_r  <= {DEN_W{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
        end else if (load) begin
            quot_r <= num;
            rem_r  <= {DEN_W{1'b0}};
            den_r  <= den;
            cnt_r  <= {CNT_W{1'b0}};
        end else if (step) begin
            quot_r <= {quot_r[NUM_W-2:0], fits_s};
            // The restored remainder is always below den_r, so it fits DEN_W bits.
            rem_r  <= fits_s ? rem_diff_s[DEN_W-1:0] : rem_shift_s[DEN_W-1:0];
            cnt_r  <= last ? {CNT_W{1'b0}} : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            quot_r <= quot_r;
            rem_r  <= rem_r;
            den_r  <= den_r;
            cnt_r  <= cnt_r;
        end
    end

    assign last      = (cnt_r == CNT_W'(DIV_ITER - 1));
    assign quotient  = quot_r;
    assign remainder = rem_r;

endmodule

// File: rtl/tr_defuzzy_seq.sv
// tr_defuzzy_seq: sequenced centroid defuzzifier for the type-2 trapezoidal
// fuzzy controller. On EN_SCLK (while idle) the six firing strengths are
// captured; the weighted position sum and total weight are formed, divided
// over 19 cycles by seq_divider, and the crisp value is registered.
//   clk, rst : clock, asynchronous active-high reset
//   dfz      : tr_defuzzy_seq_if.slave (EN_SCLK, FOU_*_UP/LOW in;
//              saida, valid, busy, div_zero, overrun out)
// Parameters: POS_1/POS_2/POS_3 output-universe positions, ZERO_OUT value
// for a zero total weight.
// Build option: define TR_DEFUZZY_ROUND_EN for round-to-nearest; otherwise
// the quotient is truncated.
module tr_defuzzy_seq
    import tr_defuzzy_seq_pkg::*;
#(
    parameter int POS_1    = 0,
    parameter int POS_2    = 128,
    parameter int POS_3    = 255,
    parameter int ZERO_OUT = 0
)
(
    input  logic            clk,
    input  logic            rst,
    tr_defuzzy_seq_if.slave dfz
);

    localparam logic [1:0] ST_IDLE = STATE_IDLE;
    localparam logic [1:0] ST_SUM  = STATE_SUM;
    localparam logic [1:0] ST_DIV  = STATE_DIV;
    localparam logic [1:0] ST_DONE = STATE_DONE;

    localparam logic [MF_W-1:0]  POS_1_C  = MF_W'(POS_1);
    localparam logic [MF_W-1:0]  POS_2_C  = MF_W'(POS_2);
    localparam logic [MF_W-1:0]  POS_3_C  = MF_W'(POS_3);
    localparam logic [OUT_W-1:0] ZERO_C   = OUT_W'(ZERO_OUT);

`ifdef TR_DEFUZZY_ROUND_EN
    localparam logic ROUND_EN = 1'b1;
`else
    localparam logic ROUND_EN = 1'b0;
`endif

    logic [1:0]       state_r;
    logic [MF_W-1:0]  up1_r, up2_r, up3_r, low1_r, low2_r, low3_r;
    logic             zero_r;
    logic [OUT_W-1:0] saida_r;
    logic             valid_r;
    logic             busy_r;
    logic             div_zero_r;
    logic             overrun_r;

    logic [FOU_W-1:0] fou1_s, fou2_s, fou3_s;
    logic [NUM_W-1:0] num_s;
    logic [DEN_W-1:0] den_s;
    logic             den_zero_s;
    logic             load_s;
    logic             step_s;
    logic [NUM_W-1:0] div_quot_s;
    logic [DEN_W-1:0] div_rem_s;
    logic             div_last_s;
    logic [OUT_W-1:0] result_s;

    // Combined FOU weights, weighted sum and total weight from the capture
    // registers; the live inputs never reach the datapath.
    always_comb begin
        fou1_s     = FOU_W'(up1_r) + FOU_W'(low1_r);
        fou2_s     = FOU_W'(up2_r) + FOU_W'(low2_r);
        fou3_s     = FOU_W'(up3_r) + FOU_W'(low3_r);
        num_s      = NUM_W'(fou1_s) * NUM_W'(POS_1_C)
                   + NUM_W'(fou2_s) * NUM_W'(POS_2_C)
                   + NUM_W'(fou3_s) * NUM_W'(POS_3_C);
        den_s      = DEN_W'(fou1_s) + DEN_W'(fou2_s) + DEN_W'(fou3_s);
        den_zero_s = (den_s == {DEN_W{1'b0}});
    end

    // Divider control decoded from the state register
    always_comb begin
        load_s = (state_r == ST_SUM) && !den_zero_s;
        step_s = (state_r == ST_DIV);
    end

    seq_divider u_div (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .step      (step_s),
        .num       (num_s),
        .den       (den_s),
        .quotient  (div_quot_s),
        .remainder (div_rem_s),
        .last      (div_last_s)
    );

    // Capture registers still hold the operands, so den_s is the divisor in DONE.
    assign result_s = round_quot(div_quot_s, div_rem_s, den_s, ROUND_EN);

    // Sequencing FSM, capture registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            up1_r      <= {MF_W{1'b0}};
            up2_r      <= {MF_W{1'b0}};
            up3_r      <= {MF_W{1'b0}};
            low1_r     <= {MF_W{1'b0}};
            low2_r     <= {MF_W{1'b0}};
            low3_r     <= {MF_W{1'b0}};
            zero_r     <= 1'b0;
            saida_r    <= {OUT_W{1'b0}};
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
            div_zero_r <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            valid_r    <= 1'b0;
            div_zero_r <= 1'b0;
            // A strobe while busy is dropped, only flagged.
            overrun_r  <= dfz.EN_SCLK && (state_r != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (dfz.EN_SCLK) begin
                        up1_r   <= dfz.FOU_1_UP;
                        up2_r   <= dfz.FOU_2_UP;
                        up3_r   <= dfz.FOU_3_UP;
                        low1_r  <= dfz.FOU_1_LOW;
                        low2_r  <= dfz.FOU_2_LOW;
                        low3_r  <= dfz.FOU_3_LOW;
                        busy_r  <= 1'b1;
                        state_r <= ST_SUM;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SUM: begin
                    zero_r  <= den_zero_s;
                    state_r <= den_zero_s ? ST_DONE : ST_DIV;
                end
                ST_DIV: begin
                    state_r <= div_last_s ? ST_DONE : ST_DIV;
                end
                ST_DONE: begin
                    if (zero_r) begin
                        saida_r    <= ZERO_C;
                        div_zero_r <= 1'b1;
                    end else begin
                        saida_r    <= result_s;
                        div_zero_r <= 1'b0;
                    end
                    valid_r <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign dfz.saida    = saida_r;
    assign dfz.valid    = valid_r;
    assign dfz.busy     = busy_r;
    assign dfz.div_zero = div_zero_r;
    assign dfz.overrun  = overrun_r;

endmodule

// File: tb/tb_tr_defuzzy_seq.sv
// Self-checking bench for tr_defuzzy_seq: scoreboard of expected results
// filled at strobe time from an integer centroid model and drained when the
// DUT pulses valid.
module tb_tr_defuzzy_seq;
    import tr_defuzzy_seq_pkg::*;

    localparam int P1 = 0;
    localparam int P2 = 128;
    localparam int P3 = 255;
    localparam int ZO = 90;

    typedef struct packed {
        logic [7:0] saida;
        logic       dz;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    tr_defuzzy_seq_if dfz();

    tr_defuzzy_seq #(.POS_1(P1), .POS_2(P2), .POS_3(P3), .ZERO_OUT(ZO)) dut (
        .clk (clk),
        .rst (rst),
        .dfz (dfz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input int u1, l1, u2, l2, u3, l3);
        int f1, f2, f3, num, den, q, r;
        exp_t e;
        f1 = u1 + l1; f2 = u2 + l2; f3 = u3 + l3;
        num = f1 * P1 + f2 * P2 + f3 * P3;
        den = f1 + f2 + f3;
        if (den == 0) begin
            e.saida = 8'(ZO);
            e.dz    = 1'b1;
        end else begin
            q = num / den;
            r = num % den;
`ifdef TR_DEFUZZY_ROUND_EN
            if (2 * r >= den) q = q + 1;
            if (q > 255) q = 255;
`endif
            e.saida = 8'(q);
            e.dz    = 1'b0;
        end
        return e;
    endfunction

    task automatic set_inputs(input int u1, l1, u2, l2, u3, l3);
        dfz.FOU_1_UP = 8'(u1); dfz.FOU_1_LOW = 8'(l1);
        dfz.FOU_2_UP = 8'(u2); dfz.FOU_2_LOW = 8'(l2);
        dfz.FOU_3_UP = 8'(u3); dfz.FOU_3_LOW = 8'(l3);
    endtask

    // Drive inputs with a one-cycle strobe, queue the expected result;
    // returns k = edge count at the capturing edge (observed on the next negedge).
    task automatic strobe(input int u1, l1, u2, l2, u3, l3, output int k);
        @(negedge clk);
        set_inputs(u1, l1, u2, l2, u3, l3);
        dfz.EN_SCLK = 1'b1;
        exp_q.push_back(model(u1, l1, u2, l2, u3, l3));
        @(negedge clk);
        k = cyc;
        dfz.EN_SCLK = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int at, output bit seen);
        seen = 1'b0;
        at = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (dfz.valid === 1'b1) begin
                seen = 1'b1;
                at = cyc;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dfz.EN_SCLK = 1'b0;
        set_inputs(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        n_checks++; if (dfz.saida !== 8'd0) begin n_fail++; $display("FAIL reset_saida: got %0d want 0", dfz.saida); end
        n_checks++; if (dfz.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", dfz.valid); end
        n_checks++; if (dfz.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", dfz.busy); end
        n_checks++; if (dfz.div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_div_zero: got %b want 0", dfz.div_zero); end
        n_checks++; if (dfz.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", dfz.overrun); end
        rst = 1'b0;
    endtask

    task automatic test_single_set();
        int k, at; bit seen; exp_t e;
        strobe(0, 0, 0, 0, 255, 255, k);
        n_checks++; if (dfz.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_k: got %b want 1", dfz.busy); end
        wait_valid(40, at, seen);
        e = exp_q.pop_front();
        n_checks++; if (!seen) begin n_fail++; $display("FAIL single_valid_timeout: got none want pulse"); end
        n_checks++; if (at !== k + 21) begin n_fail++; $display("FAIL single_latency: got edge %0d want %0d", at, k + 21); end
        n_checks++; if (dfz.saida !== 8'd255 || dfz.saida !== e.saida) begin n_fail++; $display("FAIL single_saida: got %0d want %0d", dfz.saida, e.saida); end
        n_checks++; if (dfz.div_zero !== 1'b0) begin n_fail++; $display("FAIL single_div_zero: got %b want 0", dfz.div_zero); end
        @(negedge clk);
        n_checks++; if (dfz.busy !== 1'b0 || dfz.valid !== 1'b0) begin n_fail++; $display("FAIL single_after: got busy %b valid %b want 0 0", dfz.busy, dfz.valid); end
    endtask

    task automatic test_half_round();
        int k, at; bit seen; exp_t e; logic [7:0] want;
`ifdef TR_DEFUZZY_ROUND_EN
        want = 8'd128;
`else
        want = 8'd127;
`endif
        strobe(100, 100, 0, 0, 100, 100, k);
        wait_valid(40, at, seen);
        e = exp_q.pop_front();
        n_checks++; if (!seen || at !== k + 21) begin n_fail++; $display("FAIL half_latency: got edge %0d want %0d", at, k + 21); end
        n_checks++; if (dfz.saida !== want || dfz.saida !== e.saida) begin n_fail++; $display("FAIL half_saida: got %0d want %0d", dfz.saida, want); end
    endtask

    task automatic test_zero_weight();
        int k, at; bit seen; exp_t e;
        strobe(0, 0, 0, 0, 0, 0, k);
        wait_valid(10, at, seen);
        e = exp_q.pop_front();
        n_checks++; if (!seen || at !== k + 2) begin n_fail++; $display("FAIL zero_latency: got edge %0d want %0d", at, k + 2); end
        n_checks++; if (dfz.saida !== e.saida) begin n_fail++; $display("FAIL zero_saida: got %0d want %0d", dfz.saida, e.saida); end
        n_checks++; if (dfz.div_zero !== 1'b1) begin n_fail++; $display("FAIL zero_div_zero: got %b want 1", dfz.div_zero); end
        @(negedge clk);
        n_checks++; if (dfz.busy !== 1'b0 || dfz.div_zero !== 1'b0) begin n_fail++; $display("FAIL zero_after: got busy %b div_zero %b want 0 0", dfz.busy, dfz.div_zero); end
    endtask

    task automatic test_overrun();
        int k, at, extra; bit seen; exp_t e;
        strobe(10, 20, 30, 40, 50, 60, k);
        while (cyc < k + 4) @(negedge clk);
        set_inputs(200, 200, 0, 0, 0, 0);
        dfz.EN_SCLK = 1'b1;
        @(negedge clk);
        dfz.EN_SCLK = 1'b0;
        n_checks++; if (dfz.overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_pulse: got %b want 1 at edge %0d", dfz.overrun, cyc); end
        @(negedge clk);
        n_checks++; if (dfz.overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b want 0", dfz.overrun); end
        wait_valid(40, at, seen);
        e = exp_q.pop_front();
        n_checks++; if (!seen || at !== k + 21) begin n_fail++; $display("FAIL overrun_latency: got edge %0d want %0d", at, k + 21); end
        n_checks++; if (dfz.saida !== e.saida) begin n_fail++; $display("FAIL overrun_saida: got %0d want %0d", dfz.saida, e.saida); end
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (dfz.valid === 1'b1) extra++;
        end
        n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL overrun_second_valid: got %0d pulses want 0", extra); end
    endtask

    task automatic test_reset_mid();
        int k, at, extra; bit seen; exp_t e;
        strobe(0, 0, 90, 10, 40, 0, k);
        while (cyc < k + 9) @(negedge clk);
        n_checks++; if (dfz.busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b want 1", dfz.busy); end
        rst = 1'b1;
        #1;
        void'(exp_q.pop_back());
        n_checks++; if (dfz.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", dfz.busy); end
        n_checks++; if (dfz.saida !== 8'd0) begin n_fail++; $display("FAIL rstmid_saida: got %0d want 0", dfz.saida); end
        // strobe together with reset must be ignored
        set_inputs(50, 50, 50, 50, 50, 50);
        dfz.EN_SCLK = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (dfz.busy !== 1'b0) begin n_fail++; $display("FAIL rst_wins_busy: got %b want 0", dfz.busy); end
        dfz.EN_SCLK = 1'b0;
        rst = 1'b0;
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (dfz.valid === 1'b1) extra++;
        end
        n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL rstmid_valid: got %0d pulses want 0", extra); end
        strobe(7, 3, 100, 55, 1, 200, k);
        wait_valid(40, at, seen);
        e = exp_q.pop_front();
        n_checks++; if (!seen || at !== k + 21) begin n_fail++; $display("FAIL rstmid_next_latency: got edge %0d want %0d", at, k + 21); end
        n_checks++; if (dfz.saida !== e.saida) begin n_fail++; $display("FAIL rstmid_next_saida: got %0d want %0d", dfz.saida, e.saida); end
    endtask

    task automatic test_back_to_back();
        int k, at; bit seen; exp_t e;
        int v[6];
        for (int i = 0; i < 12; i++) begin
            for (int j = 0; j < 6; j++) v[j] = int'($urandom_range(0, 255));
            if (i == 3) for (int j = 0; j < 6; j++) v[j] = 0;
            if (i == 5) begin v[0] = 1; for (int j = 1; j < 6; j++) v[j] = 0; end
            if (i == 7) begin v[0] = 0; v[1] = 0; v[2] = 0; v[3] = 0; v[4] = 0; v[5] = 1; end
            strobe(v[0], v[1], v[2], v[3], v[4], v[5], k);
            wait_valid(40, at, seen);
            e = exp_q.pop_front();
            n_checks++; if (!seen || at !== (e.dz ? k + 2 : k + 21)) begin n_fail++; $display("FAIL b2b_latency[%0d]: got edge %0d want %0d", i, at, e.dz ? k + 2 : k + 21); end
            n_checks++; if (dfz.saida !== e.saida || dfz.div_zero !== e.dz) begin n_fail++; $display("FAIL b2b_result[%0d]: got %0d/%b want %0d/%b", i, dfz.saida, dfz.div_zero, e.saida, e.dz); end
            n_checks++; if (dfz.overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun[%0d]: got %b want 0", i, dfz.overrun); end
        end
    endtask

    initial begin
        test_reset();
        test_single_set();
        test_half_round();
        test_zero_weight();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
